muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV64M multiply/divide unit sitting between the register-file read ports and write port.
//  Consumes rs1/rs2 read data, computes over many cycles while stalling the core, then
//  drives the register-file write port (wr_addr/wr_data/wr_enable) for exactly one cycle.
//  One bit per cycle: shift-add multiply, restoring divide; signs handled by magnitude + final fix.
// PARAMETERS
//  XLEN        64  operand/result width
//  REG_ADDR_W  5   destination register address width
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset, asynchronous, active-high
//  start      in   1           launch op; sampled only in IDLE
//  op         in   3           funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  rs1_data   in   XLEN        operand A (multiplicand / dividend)
//  rs2_data   in   XLEN        operand B (multiplier / divisor)
//  rd_addr    in   REG_ADDR_W  destination register
//  busy       out  1           state != IDLE; core stall request
//  done       out  1           one-cycle pulse, result valid
//  wr_data    out  XLEN        result to register file
//  wr_addr    out  REG_ADDR_W  destination to register file
//  wr_enable  out  1           = done && (wr_addr != 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, wr_enable=0, wr_data=0, wr_addr=0; all internal regs cleared.
//  Reset mid-operation aborts: no write issued, inputs latched before reset discarded.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE; fast path IDLE -> DONE.
//  IDLE: on start at edge N, latch op, rd_addr, |A|, |B|, result-sign; count=0.
//   Signedness: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
//   Result sign: MUL/MULH/MULHSU/DIV = signA^signB; REM = signA (remainder follows dividend).
//   Fast path (div ops only), goes straight to DONE at edge N:
//    B==0: DIV/DIVU -> all ones; REM/REMU -> A unchanged.
//    DIV/REM signed with A=0x8000_0000_0000_0000, B=-1: DIV -> A; REM -> 0.
//  CALC: one iteration per edge, N+1..N+64; count 0..63; after 64th iteration -> FIX.
//   Multiply: 2*XLEN unsigned product accumulator, add-then-shift on LSB of multiplier.
//   Divide: restoring; shift {rem,quo} left 1, trial subtract |B|, set quotient bit if no borrow.
//  FIX (edge N+65): negate magnitude if result-sign set; select field into wr_data:
//   MUL low XLEN; MULH/MULHSU/MULHU high XLEN; DIV/DIVU quotient; REM/REMU remainder -> DONE.
//  DONE: done=1, busy=1 for exactly one cycle; wr_data/wr_addr stable; next edge -> IDLE.
//   Iterative latency: done high in cycle after edge N+65. Fast path: done high in cycle after edge N.
//  start while busy is ignored (no queueing); back-to-back start accepted in cycle after DONE.
//  rd_addr==0: full computation runs, done pulses, wr_enable held 0.
//  wr_data/wr_addr hold last value after DONE until next FIX/fast-path load.
//  All arithmetic mod 2^XLEN (2^(2*XLEN) for product); no X propagation from unused operands.
// TESTING
//  MUL 7*6, rd=5, start at edge 0 -> busy 1 from edge 0; done=1, wr_enable=1, wr_data=42, wr_addr=5 after edge 65 only.
//  MULH -1*-1 -> 0; MULHU 0xFFFF_FFFF_FFFF_FFFF^2 -> 0xFFFF_FFFF_FFFF_FFFE; MULHSU -1*2 -> all ones.
//  DIV -7/2 -> -3 (0xFFFF_FFFF_FFFF_FFFD); REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 5/0 -> all ones, REMU 5/0 -> 5, DIV 0x8000_0000_0000_0000/-1 -> same, REM -> 0; done after edge 1.
//  Assert rst at edge 30 of a DIV -> busy=0, no wr_enable ever pulses; new MUL 3*3 then yields 9 at +65.
//  start pulsed during CALC ignored (result of first op unchanged); rd=0 op -> done=1, wr_enable=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// on operand magnitudes. The result sign is applied in a final fix-up cycle.
// Division by zero and signed overflow skip the iteration and finish at once.
// A finished result goes to the register-file write port for exactly one cycle.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   CALC  | one multiply/divide iteration per cycle, 64 cycles
//   FIX   | apply result sign, select result field into wr_data
//   DONE  | result valid for one cycle, write port active
module muldiv_unit #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       wr_data,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic                  wr_enable
);

    localparam int COUNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t state, state_nx;

    logic [COUNT_W-1:0]    count;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  neg_q;
    // multiplicand for multiply, divisor magnitude for divide
    logic [XLEN-1:0]       operand_q;
    // acc_hi: product high half / partial remainder
    // acc_lo: multiplier shifting out, product low half / quotient
    logic [XLEN-1:0]       acc_hi;
    logic [XLEN-1:0]       acc_lo;

    logic                  a_signed, b_signed;
    logic                  sign_a, sign_b;
    logic [XLEN-1:0]       a_mag, b_mag;
    logic                  res_neg;
    logic                  div_by_zero, div_ovf, fast;
    logic [XLEN-1:0]       fast_result;
    logic                  last_iter;

    logic [XLEN:0]         mul_sum;
    logic [XLEN:0]         div_trial;
    logic [XLEN-1:0]       hi_nx, lo_nx;

    logic [2*XLEN-1:0]     prod, prod_fix;
    logic [XLEN-1:0]       quo_fix, rem_fix;
    logic [XLEN-1:0]       result;

    // Operand decode: signedness, magnitudes, result sign and fast-path detection
    always_comb begin
        a_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                      (op == OP_DIV) || (op == OP_REM);
        b_signed    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sign_a      = a_signed && rs1_data[XLEN-1];
        sign_b      = b_signed && rs2_data[XLEN-1];
        a_mag       = sign_a ? ('0 - rs1_data) : rs1_data;
        b_mag       = sign_b ? ('0 - rs2_data) : rs2_data;
        // remainder takes the dividend's sign
        res_neg     = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
        div_by_zero = op[2] && (rs2_data == '0);
        div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
        fast        = div_by_zero || div_ovf;
        fast_result = '0;
        if (div_by_zero)
            fast_result = op[1] ? rs1_data : ALL_ONES;
        else
            fast_result = op[1] ? '0 : rs1_data;
        last_iter   = (count == COUNT_W'(XLEN-1));
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_q} : '0);
        div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, operand_q};
        hi_nx     = mul_sum[XLEN:1];
        lo_nx     = {mul_sum[0], acc_lo[XLEN-1:1]};
        if (op_q[2]) begin
            if (!div_trial[XLEN]) begin
                hi_nx = div_trial[XLEN-1:0];
                lo_nx = {acc_lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
                lo_nx = {acc_lo[XLEN-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and result field selection
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_q ? ('0 - prod) : prod;
        quo_fix  = neg_q ? ('0 - acc_lo) : acc_lo;
        rem_fix  = neg_q ? ('0 - acc_hi) : acc_hi;
        result   = '0;
        case (op_q)
            OP_MUL:                        result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               result = quo_fix;
            OP_REM, OP_REMU:               result = rem_fix;
            default:                       result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = fast ? ST_DONE : ST_CALC;
            ST_CALC: if (last_iter) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result/write-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            operand_q <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            wr_data   <= '0;
            wr_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        rd_q      <= rd_addr;
                        neg_q     <= res_neg;
                        count     <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= op[2] ? a_mag : b_mag;
                        operand_q <= op[2] ? b_mag : a_mag;
                        if (fast) begin
                            wr_data <= fast_result;
                            wr_addr <= rd_addr;
                        end
                    end
                end
                ST_CALC: begin
                    acc_hi <= hi_nx;
                    acc_lo <= lo_nx;
                    count  <= count + 1'b1;
                end
                ST_FIX: begin
                    wr_data <= result;
                    wr_addr <= rd_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign wr_enable = done && (wr_addr != '0);

endmodule
